// File: rtl/alu_issue_arbiter_pkg.sv
// alu_defs: shared ALU opcodes, widths and arbiter state encodings.
package alu_defs;
    localparam int DATA_W     = 64;
    localparam int OP_W       = 32;
    localparam int ALU_OP_ADD = 32;
    localparam int ALU_OP_NOP = 0;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
endpackage

// File: rtl/alu_issue_arbiter_rr_pick.sv
// rr_pick: rotating priority encoder, first set bit of req at or after ptr.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic            any
);
    always_comb begin
        grant = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NREQ]) grant = NREQ'(1) << ((int'(ptr) + k) % NREQ);
    end
    assign any = |req;
endmodule

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin sharing of one ALU, one op in flight, result to owner.
// Define ALU_ARB_LOCK_EN to let an owner keep the grant for up to 4 consecutive ops.
module alu_issue_arbiter
    import alu_defs::*;
#(
    parameter int NREQ    = 4,
    parameter int DATA_W  = alu_defs::DATA_W,
    parameter int OP_W    = alu_defs::OP_W,
    parameter int ALU_LAT = 1
) (
    input  logic                   c,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ*OP_W-1:0]   req_op,
    input  logic [NREQ-1:0]        req_lock,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [OP_W-1:0]        alu_instr,
    input  logic [DATA_W-1:0]      alu_out,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    input  logic [NREQ-1:0]        rsp_ready
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(ALU_LAT + 1);

    state_t          state, state_nx;
    logic [NREQ-1:0] grant;
    logic            any;
    logic [PW-1:0]   rr_ptr, owner, gidx;
    logic [CW-1:0]   cnt;
    logic            done, keep;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (.req(req_valid), .ptr(rr_ptr), .grant(grant), .any(any));

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) gidx = PW'(i);
    end

    assign req_ready = (state == ST_IDLE && !rst) ? grant : '0;
    assign rsp_valid = (state == ST_RESP) ? NREQ'(1) << owner : '0;
    assign done      = state == ST_RESP && rsp_ready[owner];

`ifdef ALU_ARB_LOCK_EN
    logic [1:0] lock_cnt;
    assign keep = req_lock[owner] && lock_cnt != 2'd3;
    always_ff @(posedge c or posedge rst)
        if (rst) lock_cnt <= '0;
        else if (done) lock_cnt <= keep ? lock_cnt + 2'd1 : 2'd0;
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign keep = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        state_nx = state == ST_IDLE ? (any ? ST_EXEC : ST_IDLE) :
                   state == ST_EXEC ? (cnt == '0 ? ST_RESP : ST_EXEC) :
                   (rsp_ready[owner] ? ST_IDLE : ST_RESP);
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_instr <= OP_W'(ALU_OP_NOP);
            rsp_data  <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && any) begin
                alu_a     <= req_a[gidx*DATA_W +: DATA_W];
                alu_b     <= req_b[gidx*DATA_W +: DATA_W];
                alu_instr <= req_op[gidx*OP_W +: OP_W];
                owner     <= gidx;
                cnt       <= CW'(ALU_LAT);
            end
            if (state == ST_EXEC) begin
                cnt <= cnt - CW'(1);
                if (cnt == '0) begin
                    rsp_data  <= alu_out;
                    alu_instr <= OP_W'(ALU_OP_NOP);
                end
            end
            if (done) rr_ptr <= keep ? owner : (owner == PW'(NREQ - 1) ? '0 : owner + PW'(1));
        end
    end
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed scenario tests for alu_issue_arbiter (NREQ=4, ALU_LAT=1).
module tb_alu_issue_arbiter;
    localparam int N = 4;
    localparam int DW = 64;
    localparam int OW = 32;

    logic            c = 0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_lock, rsp_valid, rsp_ready;
    logic [N*DW-1:0] req_a, req_b;
    logic [N*OW-1:0] req_op;
    logic [DW-1:0]   alu_a, alu_b, alu_out, rsp_data;
    logic [OW-1:0]   alu_instr;
    int checks = 0;
    int passed = 0;

    alu_issue_arbiter #(.NREQ(N), .DATA_W(DW), .OP_W(OW), .ALU_LAT(1)) dut (
        .c(c), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_lock(req_lock),
        .alu_a(alu_a), .alu_b(alu_b), .alu_instr(alu_instr), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    always #5 c = ~c;

    // one-cycle ALU: add for opcode 32, otherwise a recognisable junk value
    always @(posedge c) alu_out <= (alu_instr == 32'd32) ? alu_a + alu_b : 64'hDEAD;

    function automatic int idx_of(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic set_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = 64'(i * 100 + 1);
            req_b[i*DW +: DW] = 64'(i + 2);
            req_op[i*OW +: OW] = 32'd32;
        end
    endtask

    task automatic do_reset();
        @(negedge c);
        rst = 1;
        @(negedge c);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; req_valid = '0; req_lock = '0; rsp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0;
        repeat (2) @(negedge c);
        checks++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready got %b want 0000", req_ready); else passed++;
        checks++; if (rsp_valid !== 4'b0) $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); else passed++;
        checks++; if (rsp_data !== 64'd0) $display("FAIL reset_rsp_data got %0h want 0", rsp_data); else passed++;
        checks++; if (alu_a !== 64'd0 || alu_b !== 64'd0) $display("FAIL reset_alu_ab got %0h/%0h want 0/0", alu_a, alu_b); else passed++;
        checks++; if (alu_instr !== 32'd0) $display("FAIL reset_alu_instr got %0d want 0", alu_instr); else passed++;
        rst = 0;
    endtask

    task automatic test_single();
        @(negedge c);
        req_a[0 +: DW] = 64'd5; req_b[0 +: DW] = 64'd7; req_op[0 +: OW] = 32'd32;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", req_ready); else passed++;
        @(negedge c);
        req_valid = '0;
        checks++; if (alu_a !== 64'd5 || alu_b !== 64'd7 || alu_instr !== 32'd32)
            $display("FAIL single_latch got %0d/%0d/%0d want 5/7/32", alu_a, alu_b, alu_instr); else passed++;
        checks++; if (req_ready !== 4'b0) $display("FAIL single_ready_exec got %b want 0000", req_ready); else passed++;
        @(negedge c);
        checks++; if (rsp_valid !== 4'b0) $display("FAIL single_early_rsp got %b want 0000", rsp_valid); else passed++;
        @(negedge c);
        checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 64'd12)
            $display("FAIL single_rsp got %b/%0d want 0001/12", rsp_valid, rsp_data); else passed++;
        checks++; if (alu_instr !== 32'd0) $display("FAIL single_nop got %0d want 0", alu_instr); else passed++;
        rsp_ready = 4'b0001;
        @(negedge c);
        checks++; if (rsp_valid !== 4'b0) $display("FAIL single_rsp_drop got %b want 0000", rsp_valid); else passed++;
        rsp_ready = '0;
    endtask

    task automatic test_round_robin();
        int gi[$];
        int gc[$];
        set_ops();
        do_reset();
        req_valid = 4'b1111; rsp_ready = 4'b1111;
        for (int cyc = 0; cyc < 30 && gi.size() < 5; cyc++) begin
            #1;
            if (rsp_valid !== 4'b0 && gi.size() > 0) begin
                checks++;
                if (rsp_valid !== (4'b1 << gi[$]) || rsp_data !== 64'(gi[$] * 101 + 3))
                    $display("FAIL rr_rsp got %b/%0d want owner %0d data %0d", rsp_valid, rsp_data, gi[$], gi[$] * 101 + 3);
                else passed++;
            end
            if (req_ready !== 4'b0) begin gi.push_back(idx_of(req_ready)); gc.push_back(cyc); end
            @(negedge c);
        end
        req_valid = '0;
        checks++; if (gi.size() != 5) $display("FAIL rr_timeout got %0d grants want 5", gi.size()); else passed++;
        for (int k = 0; k < gi.size(); k++) begin
            checks++; if (gi[k] != k % 4) $display("FAIL rr_order[%0d] got %0d want %0d", k, gi[k], k % 4); else passed++;
            if (k > 0) begin
                checks++; if (gc[k] - gc[k-1] != 4) $display("FAIL rr_spacing[%0d] got %0d want 4", k, gc[k] - gc[k-1]); else passed++;
            end
        end
        @(negedge c); @(negedge c); @(negedge c);
    endtask

    task automatic test_stall();
        bit seen = 0;
        do_reset();
        rsp_ready = 4'b1011;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) $display("FAIL stall_grant got %b want 0100", req_ready); else passed++;
        @(negedge c);
        req_valid = 4'b1111;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge c);
            seen = rsp_valid !== 4'b0;
        end
        checks++; if (!seen) $display("FAIL stall_timeout got no rsp_valid want 0100"); else passed++;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 4'b0100 || rsp_data !== 64'd205 || req_ready !== 4'b0)
                $display("FAIL stall_hold[%0d] got %b/%0d/%b want 0100/205/0000", i, rsp_valid, rsp_data, req_ready);
            else passed++;
            @(negedge c);
        end
        rsp_ready = 4'b1111;
        req_valid = 4'b1001;
        @(negedge c);
        checks++; if (rsp_valid !== 4'b0 || req_ready !== 4'b1000)
            $display("FAIL stall_release got %b/%b want 0000/1000", rsp_valid, req_ready); else passed++;
    endtask

    task automatic test_wrap();
        bit seen = 0;
        @(negedge c);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge c);
            seen = req_ready !== 4'b0;
        end
        checks++; if (req_ready !== 4'b0001) $display("FAIL wrap_grant got %b want 0001", req_ready); else passed++;
    endtask

    task automatic test_rst_mid();
        bit bad = 0;
        @(negedge c);
        #1 rst = 1;
        #1;
        checks++; if (alu_a !== 64'd0 || alu_b !== 64'd0 || alu_instr !== 32'd0)
            $display("FAIL rstmid_alu got %0d/%0d/%0d want 0/0/0", alu_a, alu_b, alu_instr); else passed++;
        checks++; if (rsp_data !== 64'd0 || rsp_valid !== 4'b0 || req_ready !== 4'b0)
            $display("FAIL rstmid_out got %0d/%b/%b want 0/0000/0000", rsp_data, rsp_valid, req_ready); else passed++;
        req_valid = '0;
        @(negedge c);
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge c);
            if (rsp_valid !== 4'b0) bad = 1;
        end
        checks++; if (bad) $display("FAIL rstmid_no_rsp got rsp_valid after reset want none"); else passed++;
    endtask

`ifdef ALU_ARB_LOCK_EN
    task automatic test_lock();
        int gi[$];
        do_reset();
        req_lock = 4'b0010; req_valid = 4'b0110; rsp_ready = 4'b1111;
        for (int cyc = 0; cyc < 40 && gi.size() < 5; cyc++) begin
            #1;
            if (req_ready !== 4'b0) gi.push_back(idx_of(req_ready));
            @(negedge c);
        end
        req_valid = '0; req_lock = '0;
        checks++; if (gi.size() != 5) $display("FAIL lock_timeout got %0d grants want 5", gi.size()); else passed++;
        for (int k = 0; k < gi.size(); k++) begin
            checks++; if (gi[k] != (k < 4 ? 1 : 2)) $display("FAIL lock_order[%0d] got %0d want %0d", k, gi[k], k < 4 ? 1 : 2); else passed++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_wrap();
        test_rst_mid();
`ifdef ALU_ARB_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
